access_enable_fifo_reader: RTL and testbench



---
 rtl/access_enable_fifo_reader_pkg.sv | 22 ++
 rtl/access_enable_fifo_reader_buffer.sv | 76 +++++++
 rtl/access_enable_fifo_reader.sv | 123 ++++++++++++
 tb/tb_access_enable_fifo_reader.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/access_enable_fifo_reader_pkg.sv
// access_enable_fifo_reader_pkg
//   Shared helpers for the access-enable FIFO reader: the CLOG2 width macro
//   used to size pointers and counters, and the pointer wrap helper used by
//   the circular buffer.
//   No ports (package).

`ifndef ACCESS_ENABLE_FIFO_READER_CLOG2
`define ACCESS_ENABLE_FIFO_READER_CLOG2
// Never returns 0 so that a 1-entry structure still gets a 1-bit index.
`define CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package access_enable_fifo_reader_pkg;

  // Advance a pointer over a ring of 'depth' entries. The wrap is an explicit
  // compare, so depth does not have to be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/access_enable_fifo_reader_buffer.sv
// access_enable_fifo_reader_buffer
//   Circular storage for words returned by the upstream FIFO. Holds DEPTH
//   entries; write/read pointers wrap at DEPTH-1. Occupancy and a registered
//   valid flag are maintained here.
// Ports:
//   clock, reset      single clock, synchronous active-high reset
//   wr_en_i/wr_data_i capture one word (never asserted while full)
//   rd_en_i           retire the head word (only asserted while valid_o)
//   rd_data_o         head word
//   valid_o           buffer holds at least one word (registered)
//   occupancy_o       number of buffered words, 0..DEPTH

`ifndef ACCESS_ENABLE_FIFO_READER_CLOG2
`define ACCESS_ENABLE_FIFO_READER_CLOG2
`define CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

module access_enable_fifo_reader_buffer
  import access_enable_fifo_reader_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int PTR_W = `CLOG2(DEPTH),
  parameter int CNT_W = `CLOG2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] occupancy_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             valid_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (wr_en_i) wr_ptr_d = PTR_W'(wrap_inc(32'(wr_ptr_q), DEPTH));
    if (rd_en_i) rd_ptr_d = PTR_W'(wrap_inc(32'(rd_ptr_q), DEPTH));
    // Simultaneous write and read leave occupancy unchanged.
    if (wr_en_i && !rd_en_i)      occ_d = occ_q + CNT_W'(1);
    else if (!wr_en_i && rd_en_i) occ_d = occ_q - CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      valid_q  <= (occ_d != '0);
    end
  end

  // Storage needs no reset; contents are don't-care while invalid.
  always_ff @(posedge clock) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o   = mem_q[rd_ptr_q];
  assign valid_o     = valid_q;
  assign occupancy_o = occ_q;

endmodule

// File: rtl/access_enable_fifo_reader.sv
// access_enable_fifo_reader
//   Drains the read port of an access-enable FIFO and presents the words as a
//   valid/ready stream. Pops are issued against credits (buffered + in-flight
//   words) so that a read port with READ_LATENCY cycles of data latency still
//   sustains one word per cycle.
// Parameters:
//   WIDTH         data word width
//   READ_LATENCY  cycles from fifo_read_enable to valid fifo_read_data (0..4,
//                 0 = show-ahead)
// Ports:
//   clock, reset       single clock, synchronous active-high reset
//   fifo_read_enable   pop one word from upstream
//   fifo_read_data     upstream data, valid READ_LATENCY cycles after a pop
//   fifo_read_empty    upstream empty flag
//   output_valid/ready/data  downstream valid/ready stream
// Optional feature (macro ACCESS_ENABLE_FIFO_READER_STALL_COUNTER_EN):
//   adds parameter STALL_COUNTER_WIDTH and output stall_count, a saturating
//   count of cycles where the consumer was ready but no word was available.

`ifndef ACCESS_ENABLE_FIFO_READER_CLOG2
`define ACCESS_ENABLE_FIFO_READER_CLOG2
`define CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

module access_enable_fifo_reader
  import access_enable_fifo_reader_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int READ_LATENCY = 0
`ifdef ACCESS_ENABLE_FIFO_READER_STALL_COUNTER_EN
  ,
  parameter int STALL_COUNTER_WIDTH = 16
`endif
) (
  input  logic             clock,
  input  logic             reset,
  output logic             fifo_read_enable,
  input  logic [WIDTH-1:0] fifo_read_data,
  input  logic             fifo_read_empty,
  output logic             output_valid,
  input  logic             output_ready,
  output logic [WIDTH-1:0] output_data
`ifdef ACCESS_ENABLE_FIFO_READER_STALL_COUNTER_EN
  ,
  output logic [STALL_COUNTER_WIDTH-1:0] stall_count
`endif
);

  // Enough room for every word that can be in flight plus one being drained,
  // which is what keeps the issue loop from bubbling.
  localparam int BUFFER_DEPTH  = READ_LATENCY + 2;
  localparam int POINTER_WIDTH = `CLOG2(BUFFER_DEPTH);
  localparam int CNT_W         = `CLOG2(BUFFER_DEPTH + 1);

  logic [CNT_W-1:0] occupancy;
  logic [CNT_W-1:0] in_flight_q;
  logic [CNT_W:0]   credit_used;
  logic             capture;
  logic             pop;

  assign pop = output_valid && output_ready;

  // Credits come from registered state only, so output_ready never reaches
  // fifo_read_enable combinationally.
  assign credit_used      = (CNT_W+1)'(occupancy) + (CNT_W+1)'(in_flight_q);
  assign fifo_read_enable = !reset && !fifo_read_empty &&
                            (credit_used < (CNT_W+1)'(BUFFER_DEPTH));

  generate
    if (READ_LATENCY == 0) begin : g_show_ahead
      // Data is present in the pop cycle; nothing is ever in flight.
      assign capture     = fifo_read_enable;
      assign in_flight_q = '0;
    end else begin : g_latency
      logic [READ_LATENCY-1:0] lat_q;
      logic [CNT_W-1:0]        in_flight_d;

      assign capture     = lat_q[READ_LATENCY-1];
      assign in_flight_d = in_flight_q + CNT_W'(fifo_read_enable) - CNT_W'(capture);

      always_ff @(posedge clock) begin
        if (reset) begin
          lat_q       <= '0;
          in_flight_q <= '0;
        end else begin
          lat_q       <= (lat_q << 1) | READ_LATENCY'(fifo_read_enable);
          in_flight_q <= in_flight_d;
        end
      end
    end
  endgenerate

  access_enable_fifo_reader_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (BUFFER_DEPTH),
    .PTR_W (POINTER_WIDTH),
    .CNT_W (CNT_W)
  ) u_buf (
    .clock       (clock),
    .reset       (reset),
    .wr_en_i     (capture),
    .wr_data_i   (fifo_read_data),
    .rd_en_i     (pop),
    .rd_data_o   (output_data),
    .valid_o     (output_valid),
    .occupancy_o (occupancy)
  );

`ifdef ACCESS_ENABLE_FIFO_READER_STALL_COUNTER_EN
  logic [STALL_COUNTER_WIDTH-1:0] stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
    end else if (output_ready && !output_valid && !(&stall_q)) begin
      stall_q <= stall_q + STALL_COUNTER_WIDTH'(1);
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_access_enable_fifo_reader.sv
// Bench: four reader instances (READ_LATENCY 0..3) each fed by a behavioural
// access-enable FIFO. Words loaded upstream are pushed to a per-lane
// scoreboard and popped on every output handshake.

module tb_access_enable_fifo_reader;

  localparam int NL = 4;
  localparam int UM = 16384;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NL-1:0] en, vld, emp, rdy, force_emp;
  logic [7:0]    rdata [NL];
  logic [7:0]    odata [NL];
  logic [3:0]    sum_l [NL];
  logic [NL-1:0] capfull;
`ifdef ACCESS_ENABLE_FIFO_READER_STALL_COUNTER_EN
  logic [3:0]    stall_l [NL];
  logic [3:0]    obs_stall [NL];
`endif

  for (genvar g = 0; g < NL; g++) begin : g_lane
    access_enable_fifo_reader #(
      .WIDTH (8),
      .READ_LATENCY (g)
`ifdef ACCESS_ENABLE_FIFO_READER_STALL_COUNTER_EN
      , .STALL_COUNTER_WIDTH (4)
`endif
    ) u_dut (
      .clock            (clk),
      .reset            (rst),
      .fifo_read_enable (en[g]),
      .fifo_read_data   (rdata[g]),
      .fifo_read_empty  (emp[g]),
      .output_valid     (vld[g]),
      .output_ready     (rdy[g]),
      .output_data      (odata[g])
`ifdef ACCESS_ENABLE_FIFO_READER_STALL_COUNTER_EN
      , .stall_count    (stall_l[g])
`endif
    );
    assign sum_l[g]   = 4'(u_dut.occupancy) + 4'(u_dut.in_flight_q);
    assign capfull[g] = u_dut.capture && (32'(u_dut.occupancy) == g + 2);
  end

  // Upstream FIFO model
  logic [7:0] up_mem  [NL][UM];
  logic [7:0] up_pipe [NL][4];
  int         up_head [NL];
  int         up_tail [NL];

  // Scoreboards
  logic [7:0] sb0[$], sb1[$], sb2[$], sb3[$];

  int errors = 0;
  int checks = 0;
  int xfers  [NL];
  int issues [NL];

  logic [NL-1:0] obs_en, obs_vld, en_seen, prev_vld, prev_rdy, hold_ok;
  logic [7:0]    obs_data  [NL];
  logic [7:0]    prev_data [NL];
  logic [3:0]    obs_sum   [NL];

  task automatic chk(input string tag, input int lane,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s lane%0d observed=%0h expected=%0h", tag, lane, obs, exp);
    end
  endtask

  function automatic void sb_push(input int l, input logic [7:0] v);
    case (l)
      0: sb0.push_back(v);
      1: sb1.push_back(v);
      2: sb2.push_back(v);
      default: sb3.push_back(v);
    endcase
  endfunction

  // Returns 9'h100 when nothing is expected.
  function automatic logic [8:0] sb_pop(input int l);
    logic [8:0] r;
    r = 9'h100;
    case (l)
      0: if (sb0.size() > 0) r = {1'b0, sb0.pop_front()};
      1: if (sb1.size() > 0) r = {1'b0, sb1.pop_front()};
      2: if (sb2.size() > 0) r = {1'b0, sb2.pop_front()};
      default: if (sb3.size() > 0) r = {1'b0, sb3.pop_front()};
    endcase
    return r;
  endfunction

  function automatic int sb_size(input int l);
    case (l)
      0: return sb0.size();
      1: return sb1.size();
      2: return sb2.size();
      default: return sb3.size();
    endcase
  endfunction

  task automatic refresh();
    for (int l = 0; l < NL; l++) begin
      emp[l]   = (up_head[l] == up_tail[l]) || force_emp[l];
      rdata[l] = (l == 0) ? up_mem[l][up_head[l] % UM] : up_pipe[l][(l > 0) ? l - 1 : 0];
    end
  endtask

  task automatic clear_models();
    sb0.delete(); sb1.delete(); sb2.delete(); sb3.delete();
    for (int l = 0; l < NL; l++) begin
      up_head[l] = 0;
      up_tail[l] = 0;
      xfers[l]   = 0;
      issues[l]  = 0;
      for (int k = 0; k < 4; k++) up_pipe[l][k] = 8'h00;
    end
  endtask

  task automatic load(input int l, input int n, input int base, input bit rnd);
    logic [7:0] w;
    for (int i = 0; i < n; i++) begin
      w = rnd ? 8'($urandom) : 8'(base + i * 37);
      up_mem[l][up_tail[l] % UM] = w;
      up_tail[l]++;
      sb_push(l, w);
    end
    refresh();
  endtask

  // One clock: observe and check at the falling edge, then advance the
  // upstream model just after the rising edge.
  task automatic step();
    logic [8:0] e;
    logic [7:0] w;
    @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      obs_en[l]   = en[l];
      obs_vld[l]  = vld[l];
      obs_data[l] = odata[l];
      obs_sum[l]  = sum_l[l];
`ifdef ACCESS_ENABLE_FIFO_READER_STALL_COUNTER_EN
      obs_stall[l] = stall_l[l];
`endif
      en_seen[l] = en[l];
      if (en[l]) issues[l]++;
      chk("issue_while_empty", l, 32'(en[l] && emp[l]), 0);
      chk("credit_bound", l, 32'(32'(sum_l[l]) <= l + 2), 1);
      chk("capture_into_full", l, 32'(capfull[l]), 0);
      if (rst) begin
        chk("issue_in_reset", l, 32'(en[l]), 0);
      end else begin
        if (hold_ok[l] && prev_vld[l] && !prev_rdy[l]) begin
          chk("hold_valid", l, 32'(vld[l]), 1);
          chk("hold_data", l, 32'(odata[l]), 32'(prev_data[l]));
        end
        if (vld[l] && rdy[l]) begin
          xfers[l]++;
          e = sb_pop(l);
          chk("stream_data", l, 32'({1'b0, odata[l]}), 32'(e));
        end
      end
      prev_vld[l]  = vld[l];
      prev_rdy[l]  = rdy[l];
      prev_data[l] = odata[l];
      hold_ok[l]   = !rst;
    end
    @(posedge clk);
    #1;
    for (int l = 0; l < NL; l++) begin
      w = 8'h00;
      if (en_seen[l]) begin
        w = up_mem[l][up_head[l] % UM];
        up_head[l]++;
      end
      for (int k = 3; k > 0; k--) up_pipe[l][k] = up_pipe[l][k-1];
      up_pipe[l][0] = w;
    end
    refresh();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rdy = '0;
    force_emp = '0;
    clear_models();
    refresh();
    step();
    step();
    for (int l = 0; l < NL; l++) begin
      chk("reset_valid", l, 32'(obs_vld[l]), 0);
      chk("reset_enable", l, 32'(obs_en[l]), 0);
      chk("reset_credits", l, 32'(obs_sum[l]), 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    int budget;
    logic [NL-1:0] busy;
    en_seen = '0; prev_vld = '0; prev_rdy = '0; hold_ok = '0;
    rdy = '0; force_emp = '0;
    clear_models();
    refresh();

    // Show-ahead read port: three words with the consumer always ready.
    do_reset();
    load(0, 0, 0, 1'b0);
    up_mem[0][0] = 8'h11; up_mem[0][1] = 8'h22; up_mem[0][2] = 8'h33;
    up_tail[0] = 3;
    sb_push(0, 8'h11); sb_push(0, 8'h22); sb_push(0, 8'h33);
    rdy = 4'b0001;
    refresh();
    step();
    chk("rl0_first_issue", 0, 32'(obs_en[0]), 1);
    chk("rl0_cycle0_valid", 0, 32'(obs_vld[0]), 0);
    step();
    chk("rl0_cycle1_valid", 0, 32'(obs_vld[0]), 1);
    chk("rl0_word0", 0, 32'(obs_data[0]), 32'h11);
    step();
    chk("rl0_word1", 0, 32'(obs_data[0]), 32'h22);
    step();
    chk("rl0_word2", 0, 32'(obs_data[0]), 32'h33);
    step();
    chk("rl0_drained_valid", 0, 32'(obs_vld[0]), 0);

    // Two-cycle latency: 100 words back to back after the fill.
    do_reset();
    load(2, 100, 5, 1'b0);
    rdy = 4'b0100;
    step(); step(); step();
    chk("rl2_fill_valid", 2, 32'(obs_vld[2]), 0);
    for (int i = 0; i < 100; i++) begin
      step();
      chk("rl2_no_gap", 2, 32'(obs_vld[2]), 1);
    end
    step();
    chk("rl2_end_valid", 2, 32'(obs_vld[2]), 0);
    chk("rl2_count", 2, 32'(xfers[2]), 100);

    // Consumer stalled: pops stop at the buffer depth, head word held.
    do_reset();
    load(1, 10, 9, 1'b0);
    for (int i = 0; i < 10; i++) step();
    chk("stall_issue_count", 1, 32'(issues[1]), 3);
    chk("stall_enable_low", 1, 32'(obs_en[1]), 0);
    chk("stall_valid", 1, 32'(obs_vld[1]), 1);
    chk("stall_head_word", 1, 32'(obs_data[1]), 32'(8'(9)));
    rdy = 4'b0010;
    budget = 0;
    while (xfers[1] < 10 && budget < 40) begin
      step();
      budget++;
    end
    chk("stall_release_count", 1, 32'(xfers[1]), 10);

    // Random ready and upstream empty toggling on latencies 0, 1 and 3.
    do_reset();
    load(0, 10000, 0, 1'b1);
    load(1, 10000, 0, 1'b1);
    load(3, 10000, 0, 1'b1);
    budget = 0;
    busy = 4'b1011;
    while (busy != '0 && budget < 60000) begin
      for (int l = 0; l < NL; l++) begin
        rdy[l]       = (l != 2) && ($urandom_range(0, 1) == 1);
        force_emp[l] = ($urandom_range(0, 3) == 0);
      end
      refresh();
      step();
      budget++;
      for (int l = 0; l < NL; l++) if (xfers[l] >= 10000) busy[l] = 1'b0;
    end
    force_emp = '0;
    refresh();
    chk("rand_count_rl0", 0, 32'(xfers[0]), 10000);
    chk("rand_count_rl1", 1, 32'(xfers[1]), 10000);
    chk("rand_count_rl3", 3, 32'(xfers[3]), 10000);
    chk("rand_leftover_rl1", 1, 32'(sb_size(1)), 0);

    // Reset with two words in flight and one buffered.
    do_reset();
    load(2, 10, 50, 1'b0);
    step(); step(); step();
    rst = 1'b1;
    clear_models();
    refresh();
    step();
    chk("mid_credits_before_reset", 2, 32'(obs_sum[2]), 3);
    chk("mid_enable_in_reset", 2, 32'(obs_en[2]), 0);
    rst = 1'b0;
    step();
    chk("mid_after_valid", 2, 32'(obs_vld[2]), 0);
    chk("mid_after_enable", 2, 32'(obs_en[2]), 0);
    chk("mid_after_credits", 2, 32'(obs_sum[2]), 0);
    load(2, 5, 200, 1'b0);
    rdy = 4'b0100;
    budget = 0;
    while (xfers[2] < 5 && budget < 30) begin
      step();
      budget++;
    end
    chk("mid_resume_count", 2, 32'(xfers[2]), 5);

`ifdef ACCESS_ENABLE_FIFO_READER_STALL_COUNTER_EN
    // Stall counter saturates with nothing upstream and the consumer ready.
    do_reset();
    rdy = 4'b1111;
    for (int i = 0; i < 20; i++) step();
    chk("stall_count_saturated", 0, 32'(obs_stall[0]), 15);
    do_reset();
    chk("stall_count_reset", 0, 32'(obs_stall[0]), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
